regfile_write_arbiter: RTL and testbench

Shares the register file's single write port among NUM_REQ writeback sources (ALU, multdiv, memory load).
- Each source has a valid/ready handshake.
- The block grants one source per cycle, round-robin, and drives registered write controls into the regfile.
- Writes to $r0 are absorbed and never reach the port.
- Multi-write bursts (e.g. multdiv result pairs) can lock the grant until the burst finishes.

---
 rtl/regfile_arb_pkg.sv | 18 +
 rtl/regfile_write_arbiter_if.sv | 32 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/regfile_write_arbiter.sv | 135 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared widths, state type and index helper for the regfile write arbiter
package regfile_arb_pkg;

  localparam int DEF_REG_W  = 5;
  localparam int DEF_DATA_W = 32;
  localparam int R0_IDX     = 0;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  // Successor of idx in a ring of n sources.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - writeback request bundle and regfile write port
interface regfile_write_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int REG_W   = DEF_REG_W,
  parameter int DATA_W  = DEF_DATA_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*REG_W-1:0]  req_reg;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      ctrl_writeEnable;
  logic [REG_W-1:0]          ctrl_writeReg;
  logic [DATA_W-1:0]         data_writeReg;
  logic                      busy;

  // Writeback sources plus the regfile observer.
  modport master (
    output req_valid, req_last, req_reg, req_data,
    input  req_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, busy
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_last, req_reg, req_data,
    output req_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotate-priority picker with optional fixed priority
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             fixed_prio,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int               base;
  logic [IDX_W-1:0] cand;

  // Scan N positions from the priority base; the first requester found wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    base  = fixed_prio ? 0 : int'(ptr);
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'((base + k) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - regfile write-port arbiter with burst lock; REGFILE_ARB_FIXED_PRIO_EN selects fixed priority
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int REG_W   = DEF_REG_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input logic                    clock,
  input logic                    ctrl_reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_REQ);

`ifdef REGFILE_ARB_FIXED_PRIO_EN
  localparam logic FIXED_PRIO = 1'b1;
`else
  localparam logic FIXED_PRIO = 1'b0;
`endif

  arb_state_e         state, state_nxt;
  logic [PTR_W-1:0]   ptr, ptr_nxt;
  logic [PTR_W-1:0]   owner, owner_nxt;

  logic [REG_W-1:0]   reg_arr  [NUM_REQ];
  logic [DATA_W-1:0]  data_arr [NUM_REQ];

  logic [NUM_REQ-1:0] arb_grant;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_any;

  logic [NUM_REQ-1:0] ready;
  logic               accept;
  logic [PTR_W-1:0]   acc_idx;
  logic [REG_W-1:0]   acc_reg;
  logic [DATA_W-1:0]  acc_data;
  logic               acc_real;

  logic               we_q;
  logic [REG_W-1:0]   wreg_q;
  logic [DATA_W-1:0]  wdata_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign reg_arr[i]  = bus.req_reg[i*REG_W +: REG_W];
    assign data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (PTR_W)
  ) u_pick (
    .req        (bus.req_valid),
    .ptr        (ptr),
    .fixed_prio (FIXED_PRIO),
    .grant      (arb_grant),
    .idx        (arb_idx),
    .any        (arb_any)
  );

  // Grant selection and next-state: ARB picks by rotation, LOCK serves only the burst owner.
  always_comb begin
    ready     = '0;
    accept    = 1'b0;
    acc_idx   = arb_idx;
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    case (state)
      ST_ARB: begin
        ready   = arb_grant;
        accept  = arb_any;
        acc_idx = arb_idx;
        if (accept) begin
          if (bus.req_last[acc_idx]) begin
            ptr_nxt = FIXED_PRIO ? '0 : PTR_W'(wrap_inc(int'(acc_idx), NUM_REQ));
          end else begin
            state_nxt = ST_LOCK;
            owner_nxt = acc_idx;
          end
        end
      end
      ST_LOCK: begin
        acc_idx      = owner;
        accept       = bus.req_valid[owner];
        ready[owner] = accept;
        if (accept && bus.req_last[owner]) begin
          state_nxt = ST_ARB;
          ptr_nxt   = FIXED_PRIO ? '0 : PTR_W'(wrap_inc(int'(owner), NUM_REQ));
        end
      end
      default: state_nxt = ST_ARB;
    endcase
  end

  assign acc_reg  = reg_arr[acc_idx];
  assign acc_data = data_arr[acc_idx];
  // Writes to $r0 are acked but never reach the port.
  assign acc_real = accept && (acc_reg != REG_W'(R0_IDX));

  // Arbitration state: reset abandons any burst and restarts rotation at source 0.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state <= ST_ARB;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
    end
  end

  // Registered write port: enable pulses one cycle after acceptance, address/data hold otherwise.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= acc_real;
      if (acc_real) begin
        wreg_q  <= acc_reg;
        wdata_q <= acc_data;
      end
    end
  end

  assign bus.req_ready        = ctrl_reset ? ready : '0;
  assign bus.ctrl_writeEnable = we_q;
  assign bus.ctrl_writeReg    = wreg_q;
  assign bus.data_writeReg    = wdata_q;
  assign bus.busy             = (state == ST_LOCK);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
  import regfile_arb_pkg::*;

  localparam int NR = 3;
  localparam int RW = DEF_REG_W;
  localparam int DW = DEF_DATA_W;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clock = 1'b0;
  logic ctrl_reset;
  int   checks   = 0;
  int   failures = 0;

  regfile_write_arbiter_if #(.NUM_REQ(NR), .REG_W(RW), .DATA_W(DW)) bus ();

  regfile_write_arbiter #(.NUM_REQ(NR), .REG_W(RW), .DATA_W(DW)) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  // Source-side stimulus, held until accepted.
  logic [NR-1:0] s_valid;
  logic [NR-1:0] s_last;
  logic [RW-1:0] s_reg  [NR];
  logic [DW-1:0] s_data [NR];

  // Reference model: rotation start, burst owner (-1 = none), expected port contents.
  int            m_ptr;
  int            m_owner;
  logic          m_we;
  logic [RW-1:0] m_reg;
  logic [DW-1:0] m_data;

  task automatic apply();
    bus.req_valid = s_valid;
    bus.req_last  = s_last;
    for (int i = 0; i < NR; i++) begin
      bus.req_reg[i*RW +: RW]  = s_reg[i];
      bus.req_data[i*DW +: DW] = s_data[i];
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_owner = -1;
    m_we    = 1'b0;
    m_reg   = '0;
    m_data  = '0;
  endtask

  function automatic int model_grant(input logic [NR-1:0] v);
    int c;
    if (m_owner >= 0) return v[m_owner] ? m_owner : -1;
    for (int k = 0; k < NR; k++) begin
      c = ((FIXED ? 0 : m_ptr) + k) % NR;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input int g);
    m_we = 1'b0;
    if (g < 0) return;
    if (s_last[g]) begin
      m_ptr   = FIXED ? 0 : (g + 1) % NR;
      m_owner = -1;
    end else if (m_owner < 0) begin
      m_owner = g;
    end
    if (s_reg[g] != 0) begin
      m_we   = 1'b1;
      m_reg  = s_reg[g];
      m_data = s_data[g];
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    ctrl_reset = 1'b0;
    s_valid    = '0;
    s_last     = '1;
    apply();
    model_reset();
    @(negedge clock);
    ctrl_reset = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    s_valid = '1;
    apply();
    #1;
    checks++;
    if (bus.req_ready !== 3'b000 || bus.ctrl_writeEnable !== 1'b0 || bus.ctrl_writeReg !== '0 ||
        bus.data_writeReg !== '0 || bus.busy !== 1'b0)
      begin failures++; $display("FAIL reset_hold ready=%b we=%b reg=%0d data=%h busy=%b exp all 0",
        bus.req_ready, bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg, bus.busy); end
    @(negedge clock);
    ctrl_reset = 1'b1;
    s_reg[0] = 5'd1; s_reg[1] = 5'd2; s_reg[2] = 5'd3;
    s_data[0] = 32'h11; s_data[1] = 32'h22; s_data[2] = 32'h33;
    apply();
    repeat (3) @(negedge clock);
    ctrl_reset = 1'b0;
    s_valid = '0;
    apply();
    #1;
    checks++;
    if (bus.ctrl_writeEnable !== 1'b0 || bus.ctrl_writeReg !== '0 || bus.data_writeReg !== '0)
      begin failures++; $display("FAIL reset_async we=%b reg=%0d data=%h exp 0/0/0",
        bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg); end
    @(negedge clock);
    ctrl_reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      checks++;
      if (bus.req_ready !== 3'b000 || bus.ctrl_writeEnable !== 1'b0 || bus.ctrl_writeReg !== '0 ||
          bus.data_writeReg !== '0 || bus.busy !== 1'b0)
        begin failures++; $display("FAIL idle_after_reset cyc=%0d ready=%b we=%b reg=%0d data=%h busy=%b exp all 0",
          c, bus.req_ready, bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg, bus.busy); end
    end
    model_reset();
  endtask

  task automatic test_contention();
    int e;
    do_reset();
    s_valid = 3'b111; s_last = 3'b111;
    s_reg[0] = 5'd1; s_reg[1] = 5'd2; s_reg[2] = 5'd3;
    s_data[0] = 32'hAAAA_0001; s_data[1] = 32'hBBBB_0002; s_data[2] = 32'hCCCC_0003;
    apply();
    for (int k = 0; k < 9; k++) begin
      e = FIXED ? 0 : k % 3;
      #1;
      checks++;
      if (bus.req_ready !== 3'(1 << e))
        begin failures++; $display("FAIL contention_ready k=%0d got=%b exp=%b", k, bus.req_ready, 3'(1 << e)); end
      @(posedge clock); #1;
      checks++;
      if (bus.ctrl_writeEnable !== 1'b1 || bus.ctrl_writeReg !== 5'(e + 1) || bus.data_writeReg !== s_data[e])
        begin failures++; $display("FAIL contention_write k=%0d we=%b reg=%0d data=%h exp 1/%0d/%h",
          k, bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg, e + 1, s_data[e]); end
      @(negedge clock);
    end
  endtask

  task automatic test_r0_drop();
    do_reset();
    s_valid = 3'b001; s_last = 3'b111; s_reg[0] = 5'd7; s_data[0] = 32'h1234_5678;
    apply();
    @(posedge clock); #1;
    @(negedge clock);
    s_valid = 3'b010; s_reg[1] = 5'd0; s_data[1] = 32'hDEAD_BEEF;
    apply();
    #1;
    checks++;
    if (bus.req_ready !== 3'b010)
      begin failures++; $display("FAIL r0_ready got=%b exp=010", bus.req_ready); end
    @(posedge clock); #1;
    checks++;
    if (bus.ctrl_writeEnable !== 1'b0 || bus.ctrl_writeReg !== 5'd7 || bus.data_writeReg !== 32'h1234_5678)
      begin failures++; $display("FAIL r0_drop we=%b reg=%0d data=%h exp 0/7/12345678",
        bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg); end
    @(negedge clock);
    s_valid = 3'b000;
    apply();
    @(posedge clock); #1;
    checks++;
    if (bus.ctrl_writeEnable !== 1'b0 || bus.ctrl_writeReg !== 5'd7 || bus.data_writeReg !== 32'h1234_5678)
      begin failures++; $display("FAIL idle_hold we=%b reg=%0d data=%h exp 0/7/12345678",
        bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg); end
    @(negedge clock);
  endtask

  task automatic test_burst_lock();
    do_reset();
    s_last = 3'b111;
    s_reg[0] = 5'd10; s_data[0] = 32'h0A; s_valid = 3'b001; apply();
    @(negedge clock);
    s_reg[1] = 5'd11; s_data[1] = 32'h0B; s_valid = 3'b010; apply();
    @(negedge clock);
    s_reg[0] = 5'd1; s_data[0] = 32'h01; s_reg[1] = 5'd2; s_data[1] = 32'h02;
    s_reg[2] = 5'd4; s_data[2] = 32'h4444; s_last[2] = 1'b0;
    s_valid = FIXED ? 3'b100 : 3'b111;
    apply();
    #1;
    checks++;
    if (bus.req_ready !== 3'b100 || bus.busy !== 1'b0)
      begin failures++; $display("FAIL burst_start ready=%b busy=%b exp 100/0", bus.req_ready, bus.busy); end
    @(posedge clock); #1;
    checks++;
    if (bus.ctrl_writeEnable !== 1'b1 || bus.ctrl_writeReg !== 5'd4 || bus.data_writeReg !== 32'h4444 || bus.busy !== 1'b1)
      begin failures++; $display("FAIL burst_first we=%b reg=%0d data=%h busy=%b exp 1/4/4444/1",
        bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg, bus.busy); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      s_valid = 3'b011; apply();
      #1;
      checks++;
      if (bus.req_ready !== 3'b000 || bus.busy !== 1'b1)
        begin failures++; $display("FAIL burst_gap cyc=%0d ready=%b busy=%b exp 000/1", c, bus.req_ready, bus.busy); end
      @(posedge clock); #1;
      checks++;
      if (bus.ctrl_writeEnable !== 1'b0 || bus.ctrl_writeReg !== 5'd4)
        begin failures++; $display("FAIL burst_gap_out cyc=%0d we=%b reg=%0d exp 0/4", c, bus.ctrl_writeEnable, bus.ctrl_writeReg); end
    end
    @(negedge clock);
    s_valid = 3'b111; s_reg[2] = 5'd5; s_data[2] = 32'h5555; s_last[2] = 1'b1; apply();
    #1;
    checks++;
    if (bus.req_ready !== 3'b100 || bus.busy !== 1'b1)
      begin failures++; $display("FAIL burst_end ready=%b busy=%b exp 100/1", bus.req_ready, bus.busy); end
    @(posedge clock); #1;
    checks++;
    if (bus.ctrl_writeEnable !== 1'b1 || bus.ctrl_writeReg !== 5'd5 || bus.data_writeReg !== 32'h5555 || bus.busy !== 1'b0)
      begin failures++; $display("FAIL burst_second we=%b reg=%0d data=%h busy=%b exp 1/5/5555/0",
        bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg, bus.busy); end
    @(negedge clock);
    s_valid = 3'b011; apply();
    #1;
    checks++;
    if (bus.req_ready !== 3'b001)
      begin failures++; $display("FAIL after_burst_grant got=%b exp=001", bus.req_ready); end
    @(posedge clock); #1;
    checks++;
    if (bus.ctrl_writeEnable !== 1'b1 || bus.ctrl_writeReg !== 5'd1)
      begin failures++; $display("FAIL after_burst_write we=%b reg=%0d exp 1/1", bus.ctrl_writeEnable, bus.ctrl_writeReg); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    s_last = 3'b111;
    s_reg[0] = 5'd3; s_data[0] = 32'h33; s_valid = 3'b001; apply();
    @(negedge clock);
    s_reg[1] = 5'd6; s_data[1] = 32'h66; s_last[1] = 1'b0; s_valid = 3'b010; apply();
    @(posedge clock); #1;
    checks++;
    if (bus.ctrl_writeEnable !== 1'b1 || bus.ctrl_writeReg !== 5'd6 || bus.busy !== 1'b1)
      begin failures++; $display("FAIL mid_burst_pending we=%b reg=%0d busy=%b exp 1/6/1",
        bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.busy); end
    ctrl_reset = 1'b0;
    #1;
    checks++;
    if (bus.ctrl_writeEnable !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 3'b000 || bus.ctrl_writeReg !== '0)
      begin failures++; $display("FAIL mid_burst_reset we=%b busy=%b ready=%b reg=%0d exp 0/0/000/0",
        bus.ctrl_writeEnable, bus.busy, bus.req_ready, bus.ctrl_writeReg); end
    @(negedge clock);
    s_reg[0] = 5'd9; s_data[0] = 32'h99; s_reg[1] = 5'd7; s_data[1] = 32'h77;
    s_last = 3'b111; s_valid = 3'b011; apply();
    @(negedge clock);
    ctrl_reset = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 3'b001 || bus.busy !== 1'b0)
      begin failures++; $display("FAIL post_reset_grant ready=%b busy=%b exp 001/0", bus.req_ready, bus.busy); end
    @(posedge clock); #1;
    checks++;
    if (bus.ctrl_writeEnable !== 1'b1 || bus.ctrl_writeReg !== 5'd9 || bus.data_writeReg !== 32'h99)
      begin failures++; $display("FAIL post_reset_write we=%b reg=%0d data=%h exp 1/9/99",
        bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg); end
    @(negedge clock);
  endtask

  task automatic test_priority_policy();
    logic [NR-1:0] e;
    do_reset();
    s_last = 3'b111; s_reg[0] = 5'd12; s_data[0] = 32'hC0; s_reg[2] = 5'd14; s_data[2] = 32'hE0;
    s_valid = 3'b101; apply();
    for (int k = 0; k < 6; k++) begin
      e = (FIXED || (k % 2 == 0)) ? 3'b001 : 3'b100;
      #1;
      checks++;
      if (bus.req_ready !== e)
        begin failures++; $display("FAIL policy_ready k=%0d got=%b exp=%b", k, bus.req_ready, e); end
      @(posedge clock); #1;
      @(negedge clock);
    end
    s_valid = 3'b100; apply();
    #1;
    checks++;
    if (bus.req_ready !== 3'b100)
      begin failures++; $display("FAIL policy_fallback got=%b exp=100", bus.req_ready); end
    @(posedge clock); #1;
    checks++;
    if (bus.ctrl_writeEnable !== 1'b1 || bus.ctrl_writeReg !== 5'd14)
      begin failures++; $display("FAIL policy_fallback_write we=%b reg=%0d exp 1/14", bus.ctrl_writeEnable, bus.ctrl_writeReg); end
    @(negedge clock);
  endtask

  task automatic test_random();
    int            g;
    logic [NR-1:0] e;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NR; i++) begin
        if (!s_valid[i] && $urandom_range(0, 99) < 60) begin
          s_valid[i] = 1'b1;
          s_last[i]  = ($urandom_range(0, 3) != 0);
          s_reg[i]   = ($urandom_range(0, 7) == 0) ? 5'd0 : RW'($urandom_range(1, 31));
          s_data[i]  = $urandom;
        end
      end
      apply();
      #1;
      g = model_grant(s_valid);
      e = (g < 0) ? 3'b000 : 3'(1 << g);
      checks++;
      if (bus.req_ready !== e || bus.busy !== (m_owner >= 0))
        begin failures++; $display("FAIL rand_ready cyc=%0d ready=%b busy=%b exp %b/%b",
          cyc, bus.req_ready, bus.busy, e, m_owner >= 0); end
      checks++;
      if ($countones(bus.req_ready) > 1)
        begin failures++; $display("FAIL rand_onehot cyc=%0d ready=%b exp at most one bit", cyc, bus.req_ready); end
      @(posedge clock); #1;
      model_step(g);
      if (g >= 0) s_valid[g] = 1'b0;
      checks++;
      if (bus.ctrl_writeEnable !== m_we || bus.ctrl_writeReg !== m_reg || bus.data_writeReg !== m_data)
        begin failures++; $display("FAIL rand_write cyc=%0d we=%b reg=%0d data=%h exp %b/%0d/%h",
          cyc, bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg, m_we, m_reg, m_data); end
      @(negedge clock);
    end
  endtask

  initial begin
    ctrl_reset = 1'b0;
    s_valid    = '0;
    s_last     = '1;
    for (int i = 0; i < NR; i++) begin
      s_reg[i]  = '0;
      s_data[i] = '0;
    end
    apply();
    model_reset();
    test_reset();
    test_contention();
    test_r0_drop();
    test_burst_lock();
    test_reset_mid_burst();
    test_priority_policy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
